seq_divider: RTL

//  Iterative unsigned divider: 2N-bit dividend / N-bit divisor -> N-bit quotient + N-bit remainder.

---
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Divider handshake bundle: request side (dividend/divisor) and result side (quotient/remainder/err).
// Combinational wiring only; no latency of its own.
// Both directions use valid/ready; master drives requests and result-ready, slave is the divider.
interface seq_divider_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           err;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, err
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, err
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Latency N+1 cycles (N/2+1 with DIV_RADIX4_EN), 1 cycle on overflow/divide-by-zero.
// One op in flight: in_ready only when idle; result held in DONE until out_ready.
module seq_divider #(
  parameter int N = 16
) (
  input  logic clk,
  input  logic rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(N) + 1;
`ifdef DIV_RADIX4_EN
  localparam int STEPS = N / 2;
`else
  localparam int STEPS = N;
`endif
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  // Partial remainder; its extra (N+1th) bit only exists transiently inside a step,
  // because the remainder after every step is strictly below the divisor.
  logic [N-1:0]  rem_q;
  // Dividend low bits shift out at the MSB while quotient bits shift in at the LSB;
  // after the last step this register holds the quotient.
  logic [N-1:0]  shq_q;
  logic [N-1:0]  dvsr_q;
  logic [CW-1:0] cnt_q;

  logic [N-1:0]  quo_o, rem_o;
  logic          err_o;

  logic          xfer, ovf, last_step;
  logic [N-1:0]  rem_d, shq_d;

  // One restoring step: returns {qbit, next remainder}.
  function automatic logic [N:0] div_step(input logic [N-1:0] r, input logic b,
                                          input logic [N-1:0] d);
    logic [N:0] sh;
    sh = {r, b};
    if (sh >= {1'b0, d}) return {1'b1, N'(sh - {1'b0, d})};
    else                 return {1'b0, sh[N-1:0]};
  endfunction

  assign xfer      = bus.in_valid && (state_q == IDLE);
  assign ovf       = bus.dividend[2*N-1:N] >= bus.divisor;
  assign last_step = (cnt_q == LAST);

  // Combinational step(s) applied each RUN cycle.
`ifdef DIV_RADIX4_EN
  logic [N:0] s1, s2;
  always_comb begin
    s1    = div_step(rem_q, shq_q[N-1], dvsr_q);
    s2    = div_step(s1[N-1:0], shq_q[N-2], dvsr_q);
    rem_d = s2[N-1:0];
    shq_d = {shq_q[N-3:0], s1[N], s2[N]};
  end
`else
  logic [N:0] s1;
  always_comb begin
    s1    = div_step(rem_q, shq_q[N-1], dvsr_q);
    rem_d = s1[N-1:0];
    shq_d = {shq_q[N-2:0], s1[N]};
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = ovf ? DONE : RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture at transfer and iteration while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      shq_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (xfer) begin
      rem_q  <= bus.dividend[2*N-1:N];
      shq_q  <= bus.dividend[N-1:0];
      dvsr_q <= bus.divisor;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      rem_q <= rem_d;
      shq_q <= shq_d;
      if (!last_step) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Result registers update only on entry to DONE, so they stay put under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_o <= '0;
      rem_o <= '0;
      err_o <= 1'b0;
    end else if (xfer && ovf) begin
      quo_o <= '1;
      rem_o <= bus.dividend[N-1:0];
      err_o <= 1'b1;
    end else if ((state_q == RUN) && last_step) begin
      quo_o <= shq_d;
      rem_o <= rem_d;
      err_o <= 1'b0;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_o;
  assign bus.remainder = rem_o;
  assign bus.err       = err_o;

endmodule
